// File: rtl/instr_loader_pkg.sv
// Shared types and constants for the instruction memory loader.
// Optional feature macro used by this block: INSTR_LOADER_CKSUM_EN.
package instr_loader_pkg;

    localparam int unsigned LOADER_AW    = 12;
    localparam int unsigned LOADER_DEPTH = 2 ** LOADER_AW;

    // addi x0, x0, 0 -- returned for any fetch before a program is loaded
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StDone
    } loader_state_e;

endpackage

// File: rtl/instr_mem_loader_if.sv
// Byte-stream valid/ready link from the host/UART source into the loader.
interface instr_mem_loader_if #(
    parameter int unsigned DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] byte_data;
    logic                  byte_valid;
    logic                  byte_ready;

    modport master (output byte_data, output byte_valid, input byte_ready);
    modport slave  (input byte_data, input byte_valid, output byte_ready);
endinterface

// File: rtl/byte_ram.sv
// Byte array: one synchronous write port, four combinational read ports.
module byte_ram #(
    parameter int unsigned AW = 12,
    parameter int unsigned DW = 8
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr0,
    input  logic [AW-1:0] raddr1,
    input  logic [AW-1:0] raddr2,
    input  logic [AW-1:0] raddr3,
    output logic [DW-1:0] rdata0,
    output logic [DW-1:0] rdata1,
    output logic [DW-1:0] rdata2,
    output logic [DW-1:0] rdata3
);
    logic [DW-1:0] mem [2 ** AW];

    // Contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata0 = mem[raddr0];
    assign rdata1 = mem[raddr1];
    assign rdata2 = mem[raddr2];
    assign rdata3 = mem[raddr3];
endmodule

// File: rtl/instr_mem_loader.sv
// Loads a byte-stream program into a private array and serves 32-bit fetches from it.
// Define INSTR_LOADER_CKSUM_EN to add the cksum output.
module instr_mem_loader
    import instr_loader_pkg::*;
#(
    parameter int unsigned ADDRESS_WIDTH = 32,
    parameter int unsigned DATA_WIDTH    = 8,
    parameter int unsigned OUT_WIDTH     = 32,
    parameter int unsigned AW            = LOADER_AW
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     load_start,
    input  logic [AW:0]              load_len,
    instr_mem_loader_if.slave        bs,
    output logic                     busy,
    output logic                     load_done,
    output logic                     cpu_run,
    input  logic [ADDRESS_WIDTH-1:0] A,
    output logic [OUT_WIDTH-1:0]     RD
`ifdef INSTR_LOADER_CKSUM_EN
    ,
    output logic [7:0]               cksum
`endif
);
    localparam logic [AW:0] DEPTH_LEN = (AW + 1)'(2 ** AW);

    loader_state_e state_q, state_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0]   remaining_q, remaining_d;
    logic [AW:0]   clamped_len;
    logic          we;

    logic [AW-1:0]         addr;
    logic [DATA_WIDTH-1:0] b0, b1, b2, b3;
    logic                  unused_addr;

`ifdef INSTR_LOADER_CKSUM_EN
    logic [7:0] cksum_q, cksum_d;
`endif

    assign clamped_len = (load_len > DEPTH_LEN) ? DEPTH_LEN : load_len;

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        remaining_d = remaining_q;
        we          = 1'b0;
`ifdef INSTR_LOADER_CKSUM_EN
        cksum_d     = cksum_q;
`endif
        unique case (state_q)
            StIdle, StDone: begin
                if (load_start) begin
`ifdef INSTR_LOADER_CKSUM_EN
                    cksum_d = 8'h00;
`endif
                    if (load_len == '0) begin
                        state_d = StDone;
                    end else begin
                        state_d     = StLoad;
                        wr_ptr_d    = '0;
                        remaining_d = clamped_len;
                    end
                end
            end
            StLoad: begin
                // byte_ready is high for the whole of LOAD, so valid alone qualifies a transfer
                if (bs.byte_valid) begin
                    we          = 1'b1;
                    wr_ptr_d    = wr_ptr_q + AW'(1);
                    remaining_d = remaining_q - (AW + 1)'(1);
`ifdef INSTR_LOADER_CKSUM_EN
                    cksum_d     = cksum_q + 8'(bs.byte_data);
`endif
                    if (remaining_q == (AW + 1)'(1)) begin
                        state_d = StDone;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            wr_ptr_q    <= '0;
            remaining_q <= '0;
`ifdef INSTR_LOADER_CKSUM_EN
            cksum_q     <= 8'h00;
`endif
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            remaining_q <= remaining_d;
`ifdef INSTR_LOADER_CKSUM_EN
            cksum_q     <= cksum_d;
`endif
        end
    end

    assign bs.byte_ready = (state_q == StLoad);
    assign busy          = (state_q == StLoad);
    assign load_done     = (state_q == StDone);
    assign cpu_run       = (state_q == StDone);

`ifdef INSTR_LOADER_CKSUM_EN
    assign cksum = cksum_q;
`endif

    assign addr        = A[AW-1:0];
    assign unused_addr = ^A[ADDRESS_WIDTH-1:AW];

    byte_ram #(
        .AW(AW),
        .DW(DATA_WIDTH)
    ) u_ram (
        .clk    (clk),
        .we     (we),
        .waddr  (wr_ptr_q),
        .wdata  (bs.byte_data),
        .raddr0 (addr),
        .raddr1 (addr + AW'(1)),
        .raddr2 (addr + AW'(2)),
        .raddr3 (addr + AW'(3)),
        .rdata0 (b0),
        .rdata1 (b1),
        .rdata2 (b2),
        .rdata3 (b3)
    );

    assign RD = (state_q == StDone) ? OUT_WIDTH'({b3, b2, b1, b0}) : OUT_WIDTH'(NOP_INSTR);
endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed bench for instr_mem_loader; cksum checks run when INSTR_LOADER_CKSUM_EN is defined.
module tb_instr_mem_loader;
    import instr_loader_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        load_start;
    logic [12:0] load_len;
    logic        busy, load_done, cpu_run;
    logic [31:0] a;
    logic [31:0] rd;
`ifdef INSTR_LOADER_CKSUM_EN
    logic [7:0]  cksum;
`endif

    int tests_run    = 0;
    int tests_failed = 0;

    logic [7:0] prog1 [8] = '{8'h13, 8'h05, 8'hA0, 8'h00, 8'h93, 8'h05, 8'hB0, 8'h00};

    always #5 clk = ~clk;

    instr_mem_loader_if #(.DATA_WIDTH(8)) bs ();

    instr_mem_loader dut (
        .clk        (clk),
        .rst        (rst),
        .load_start (load_start),
        .load_len   (load_len),
        .bs         (bs.slave),
        .busy       (busy),
        .load_done  (load_done),
        .cpu_run    (cpu_run),
        .A          (a),
        .RD         (rd)
`ifdef INSTR_LOADER_CKSUM_EN
        ,
        .cksum      (cksum)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        assert (got === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled on the falling edge.
    task automatic step();
        @(negedge clk);
    endtask

    function automatic logic [7:0] pat(input int i);
        return 8'((i * 13) + (i >> 8));
    endfunction

    initial begin
        rst = 1'b1; load_start = 1'b0; load_len = '0;
        bs.byte_data = '0; bs.byte_valid = 1'b0; a = '0;
        step(); step();
        rst = 1'b0;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ready", 32'(bs.byte_ready), 32'd0);
        chk("rst_done", 32'(load_done), 32'd0);
        chk("rst_run", 32'(cpu_run), 32'd0);
        chk("rst_rd_nop", rd, 32'h0000_0013);

        // 1: contiguous 8-byte load
        load_start = 1'b1; load_len = 13'd8;
        step();
        load_start = 1'b0;
        chk("t1_busy", 32'(busy), 32'd1);
        chk("t1_ready", 32'(bs.byte_ready), 32'd1);
        for (int i = 0; i < 8; i++) begin
            bs.byte_data = prog1[i]; bs.byte_valid = 1'b1;
            step();
            if (i == 6) chk("t1_not_done_early", 32'(load_done), 32'd0);
        end
        bs.byte_valid = 1'b0;
        chk("t1_done", 32'(load_done), 32'd1);
        chk("t1_run", 32'(cpu_run), 32'd1);
        chk("t1_ready_low", 32'(bs.byte_ready), 32'd0);
        a = 32'd0; #1 chk("t1_rd0", rd, 32'h00A0_0513);
        a = 32'd4; #1 chk("t1_rd4", rd, 32'h00B0_0593);
        a = 32'd2; #1 chk("t1_rd2_misaligned", rd, 32'h0593_00A0);

        // 2: valid toggling, 16 cycles to DONE; reload from DONE drops cpu_run
        step();
        load_start = 1'b1; load_len = 13'd8;
        step();
        load_start = 1'b0;
        for (int i = 0; i < 16; i++) begin
            bs.byte_valid = (i % 2) == 1;
            bs.byte_data  = bs.byte_valid ? 8'(8'h11 * (i / 2 + 1)) : 8'hEE;
            chk($sformatf("t2_ready_%0d", i), 32'(bs.byte_ready), 32'd1);
            chk($sformatf("t2_run_low_%0d", i), 32'(cpu_run), 32'd0);
            step();
        end
        bs.byte_valid = 1'b0;
        chk("t2_done", 32'(load_done), 32'd1);
        a = 32'd0; #1 chk("t2_rd0", rd, 32'h4433_2211);
        a = 32'd4; #1 chk("t2_rd4", rd, 32'h8877_6655);

        // 3/4: abort after 3 bytes; load_start inside LOAD is ignored
        step();
        load_start = 1'b1; load_len = 13'd8;
        step();
        load_start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bs.byte_data = 8'(8'hAA + 8'h11 * i); bs.byte_valid = 1'b1;
            if (i == 2) begin
                load_start = 1'b1; load_len = 13'd0;
            end
            step();
        end
        bs.byte_valid = 1'b0; load_start = 1'b0;
        chk("t3_still_busy", 32'(busy), 32'd1);
        chk("t3_run_low", 32'(cpu_run), 32'd0);
        a = 32'd0;     #1 chk("t3_rd_nop_a0", rd, 32'h0000_0013);
        a = 32'h123;   #1 chk("t3_rd_nop_a123", rd, 32'h0000_0013);
        step();
        rst = 1'b1; load_start = 1'b1; load_len = 13'd4;
        step();
        rst = 1'b0; load_start = 1'b0;
        chk("t4_busy", 32'(busy), 32'd0);
        chk("t4_ready", 32'(bs.byte_ready), 32'd0);
        chk("t4_run", 32'(cpu_run), 32'd0);
        chk("t4_done", 32'(load_done), 32'd0);
        chk("t4_rd_nop", rd, 32'h0000_0013);
        load_start = 1'b1; load_len = 13'd4;
        step();
        load_start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bs.byte_data = 8'(i + 1); bs.byte_valid = 1'b1;
            step();
        end
        bs.byte_valid = 1'b0;
        chk("t4_reload_done", 32'(load_done), 32'd1);
        a = 32'd0; #1 chk("t4_rd0", rd, 32'h0403_0201);
        a = 32'd4; #1 chk("t4_rd4_kept", rd, 32'h8877_6655);

        // 5: zero length, then clamped 5000-byte load
        step();
        rst = 1'b1;
        step();
        rst = 1'b0; load_start = 1'b1; load_len = 13'd0;
        step();
        load_start = 1'b0;
        chk("t5_zero_done", 32'(load_done), 32'd1);
        chk("t5_zero_busy", 32'(busy), 32'd0);
        load_start = 1'b1; load_len = 13'd5000;
        step();
        load_start = 1'b0;
        for (int i = 0; i < 4096; i++) begin
            bs.byte_data = pat(i); bs.byte_valid = 1'b1;
            if (i == 4095) chk("t5_busy_last", 32'(busy), 32'd1);
            step();
        end
        for (int i = 0; i < 3; i++) begin
            bs.byte_data = 8'h5A;
            chk($sformatf("t5_no_excess_%0d", i), 32'(bs.byte_ready), 32'd0);
            step();
        end
        bs.byte_valid = 1'b0;
        chk("t5_clamp_done", 32'(load_done), 32'd1);
        a = 32'h0000_0FFE; #1 chk("t5_rd_ffe", rd, {pat(1), pat(0), pat(4095), pat(4094)});
        a = 32'h0000_0FFF; #1 chk("t5_rd_fff", rd, {pat(2), pat(1), pat(0), pat(4095)});
        a = 32'hABCD_0000; #1 chk("t5_rd_hi_bits", rd, {pat(3), pat(2), pat(1), pat(0)});

`ifdef INSTR_LOADER_CKSUM_EN
        // 6: checksum accumulates accepted bytes and clears on load_start
        step();
        load_start = 1'b1; load_len = 13'd3;
        step();
        load_start = 1'b0;
        chk("t6_cksum_cleared", 32'(cksum), 32'h00);
        bs.byte_valid = 1'b1;
        bs.byte_data = 8'hFF; step();
        bs.byte_valid = 1'b0; bs.byte_data = 8'h77; step();
        bs.byte_valid = 1'b1;
        bs.byte_data = 8'h02; step();
        bs.byte_data = 8'h10; step();
        bs.byte_valid = 1'b0;
        chk("t6_done", 32'(load_done), 32'd1);
        chk("t6_cksum", 32'(cksum), 32'h11);
        step();
        chk("t6_cksum_stable", 32'(cksum), 32'h11);
        load_start = 1'b1; load_len = 13'd2;
        step();
        load_start = 1'b0;
        chk("t6_cksum_clear", 32'(cksum), 32'h00);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/instr_mem_loader.md
Name: instr_mem_loader

Overview:
Write-side counterpart of the instruction fetch memory.
- Accepts a program as a byte stream through a valid/ready handshake and writes it little-endian into a private 4 KiB byte array, starting at address 0.
- Serves combinational 32-bit instruction fetches from the same array.
- Holds the CPU idle (cpu_run low) until a load has completed.
- Sits between the host/UART byte source and the fetch stage.

Parameters:
ADDRESS_WIDTH, 32, fetch address width (only bits [AW-1:0] used)
DATA_WIDTH, 8, byte width of array and stream
OUT_WIDTH, 32, fetch word width
AW, 12, array index width; depth = 2**AW bytes

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous, active-high reset
load_start  in  1  one-cycle pulse to begin a load
load_len  in  AW+1  byte count, sampled with load_start
byte_data  in  DATA_WIDTH  stream byte
byte_valid  in  1  byte_data valid
byte_ready  out  1  loader accepts a byte this cycle
busy  out  1  high while in LOAD
load_done  out  1  level, high in DONE
cpu_run  out  1  CPU enable, high in DONE
A  in  ADDRESS_WIDTH  fetch byte address
RD  out  OUT_WIDTH  fetched instruction word

Behaviour:
- FSM states: IDLE, LOAD, DONE.
- Reset (synchronous) forces:
  - state=IDLE, wr_ptr=0, remaining=0
  - byte_ready=0, busy=0, load_done=0, cpu_run=0
  - Array contents are NOT cleared.
- IDLE:
  - load_start with load_len=0 -> DONE.
  - load_start with load_len>0 -> LOAD, with wr_ptr=0 and remaining=min(load_len, 2**AW).
- LOAD:
  - byte_ready=1 and busy=1 combinationally from state.
  - Transfer occurs when byte_valid&&byte_ready. On that edge: array[wr_ptr]<=byte_data, wr_ptr++, remaining--.
  - The transfer with remaining==1 moves the FSM to DONE on the same edge. load_done/cpu_run go high the next cycle.
  - load_start is ignored while in LOAD.
  - byte_valid low stalls the load indefinitely; there is no timeout.
- DONE:
  - load_done=1, cpu_run=1, byte_ready=0.
  - load_start -> LOAD as in IDLE; cpu_run drops on that edge. A zero-length load_start stays in DONE.
- Length clamp: load_len > 2**AW is clamped to 2**AW; excess bytes are never accepted.
- Fetch (combinational):
  - addr=A[AW-1:0]; RD={arr[addr+3],arr[addr+2],arr[addr+1],arr[addr]}.
  - Byte indices wrap mod 2**AW; misaligned addresses are permitted.
  - When state != DONE, RD = 32'h0000_0013 (NOP), so a stray fetch is harmless.
- Write-to-read: a byte written on edge N is visible on RD once state==DONE.
- Reset mid-LOAD aborts the load. Partially written bytes remain; the FSM returns to IDLE with cpu_run=0.
- Simultaneous rst and load_start: rst wins.

Optional Feature:
INSTR_LOADER_CKSUM_EN
- Defined: adds output cksum[7:0], the mod-256 sum of all bytes accepted since the last load_start.
  - Cleared on rst and on every accepted load_start.
  - Updated on each transfer edge and stable in DONE.
- Undefined: no port and no checksum logic.

Decomposition:
- Package instr_loader_pkg holds:
  - state enum {IDLE, LOAD, DONE}
  - NOP_INSTR = 32'h0000_0013
  - AW default and derived DEPTH = 2**AW
- One sub-module, byte_ram:
  - 2**AW x 8 array, one synchronous write port, four combinational read ports.
  - instr_mem_loader holds the FSM, pointer, counters and checksum.

Test Plan:
1. Reset, then load_start with len=8 and bytes 13 05 A0 00 93 05 B0 00, always valid. Required: 8 transfers in 8 cycles; load_done high 1 cycle after the last transfer; A=0 -> RD=00A00513; A=4 -> RD=00B00593.
2. Same load with byte_valid toggling every other cycle. Required: 16 cycles to DONE, identical contents; byte_ready stays high throughout LOAD.
3. Fetch while in LOAD or IDLE at any A. Required: RD=00000013 and cpu_run=0.
4. Assert rst after 3 of 8 bytes. Required: IDLE, cpu_run=0, byte_ready=0. A new len=4 load then overwrites bytes 0-3 and reaches DONE.
5. load_len=0 -> DONE next cycle. load_len=5000 -> exactly 4096 bytes accepted. A=0xFFE then gives RD={arr[1],arr[0],arr[4095],arr[4094]}.
6. With INSTR_LOADER_CKSUM_EN and bytes FF 02 10: cksum=0x11 in DONE. cksum clears to 0 on the next load_start.
